uart_rx_frame: RTL

Asynchronous serial receiver for the UART path: it samples the incoming 8N1 line (1 start bit, 8 data bits LSB first, 1 stop bit) and recovers each byte. It uses the same baud-divider scheme as the transmitter, at 12 MHz / 9600 baud, and sits directly downstream of the TX line. Each recovered byte is held in a valid/ack register for the consumer. Framing errors and overruns are flagged.

---
 rtl/uart_rx_frame.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/uart_rx_frame.sv
// 8N1 UART receiver: synchronised line, mid-bit sampling, valid/ack byte holding,
// one-cycle framing-error pulse and sticky overrun flag.
module uart_rx_frame #(
    parameter int unsigned FREQ = 12000000,
    parameter int unsigned BAUD = 9600
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       rx_i,
    input  logic       rx_ack_i,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       busy_o,
    output logic [1:0] state_o
);
    localparam int unsigned CLKS_PER_BIT = FREQ / BAUD;
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned CntW         = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] HalfLast = CntW'(HALF_BIT - 1);
    localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StStop  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic            rx_meta_q, rx_s_q, rx_p_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            rx_valid_q, rx_valid_d;
    logic            frame_err_q, frame_err_d;
    logic            overrun_q, overrun_d;
    logic            busy_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        frame_err_d = 1'b0;
        overrun_d   = overrun_q;

        if (rx_ack_i && rx_valid_q) begin
            rx_valid_d = 1'b0;
            overrun_d  = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                // Only a fresh high-to-low transition starts a frame.
                if (rx_p_q && !rx_s_q) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (cnt_q == HalfLast) begin
                    cnt_d = '0;
                    if (!rx_s_q) begin
                        state_d   = StData;
                        bit_idx_d = 3'd0;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StData: begin
                if (cnt_q == BitLast) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (cnt_q == BitLast) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                    if (rx_s_q) begin
                        // A same-edge ack frees the holding register for the new byte.
                        if (!rx_valid_q || rx_ack_i) begin
                            rx_data_d  = shift_q;
                            rx_valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_p_q      <= 1'b1;
            state_q     <= StIdle;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            rx_meta_q   <= rx_i;
            rx_s_q      <= rx_meta_q;
            rx_p_q      <= rx_s_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            busy_q      <= (state_d != StIdle);
        end
    end

    assign rx_data_o   = rx_data_q;
    assign rx_valid_o  = rx_valid_q;
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;
    assign busy_o      = busy_q;
    assign state_o     = state_q;

endmodule
